// File: rtl/rf_bypass_sb.sv
// Integer register file with x0 hardwired to zero, optional write-to-read bypass,
// and a pending-write scoreboard that lets decode stall on long-latency operands.
module rf_bypass_sb #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int AW        = $clog2(NREG),
    parameter int BYPASS    = 1,
    parameter int RST_CLEAR = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we3,
    input  logic [AW-1:0]   a3,
    input  logic [XLEN-1:0] wd3,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_addr,
    output logic            busy1,
    output logic            busy2,
    output logic            stall
);

    logic [XLEN-1:0] rf_reg  [NREG];
    logic [XLEN-1:0] rf_next [NREG];
    logic [NREG-1:0] pend_reg;
    logic [NREG-1:0] pend_next;
    logic            wr_act;
    logic [AW-1:0]   raddr [2];
    logic [XLEN-1:0] rdata [2];
    logic [1:0]      busy_w;

    assign wr_act = we3 && (a3 != '0);

    // Per-register next state; a set on the register being retired wins,
    // because a new producer has been issued behind the one writing back.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
        if (gi == 0) begin : g_zero
            assign rf_next[gi]   = '0;
            assign pend_next[gi] = 1'b0;
        end else begin : g_reg
            logic hit_wr;
            logic hit_set;
            assign hit_wr        = wr_act && (a3 == AW'(gi));
            assign hit_set       = sb_set && (sb_addr == AW'(gi));
            assign rf_next[gi]   = hit_wr ? wd3 : rf_reg[gi];
            assign pend_next[gi] = hit_set || (pend_reg[gi] && !hit_wr);
        end
    end

    if (RST_CLEAR != 0) begin : g_rf_clr
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < NREG; i++) rf_reg[i] <= '0;
            end else begin
                for (int i = 0; i < NREG; i++) rf_reg[i] <= rf_next[i];
            end
        end
    end else begin : g_rf_keep
        // Contents survive reset; only the write itself is suppressed.
        always_ff @(posedge clk) begin
            if (!reset) begin
                for (int i = 0; i < NREG; i++) rf_reg[i] <= rf_next[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend_reg <= '0;
        else       pend_reg <= pend_next;
    end

    assign raddr[0] = a1;
    assign raddr[1] = a2;

    // Forwarded write data both supplies the operand and satisfies its busy bit.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic byp;
        assign byp = (BYPASS != 0) && !reset && wr_act && (a3 == raddr[gi]);
        assign rdata[gi] = ((raddr[gi] == '0) || (reset && (RST_CLEAR != 0))) ? '0 :
                           byp ? wd3 : rf_reg[raddr[gi]];
        assign busy_w[gi] = !reset && pend_reg[raddr[gi]] && (raddr[gi] != '0) && !byp;
    end

    assign rd1   = rdata[0];
    assign rd2   = rdata[1];
    assign busy1 = busy_w[0];
    assign busy2 = busy_w[1];
    assign stall = |busy_w;

endmodule

// File: tb/tb_rf_bypass_sb.sv
// Bench for rf_bypass_sb: a bypassing/clearing instance and a non-bypassing,
// non-clearing instance share stimulus; a negedge monitor checks queued expectations.
module tb_rf_bypass_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [31:0] rd1, rd2, n_rd1, n_rd2;
    logic        busy1, busy2, stall, n_busy1, n_busy2, n_stall;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        bit          unb;
        logic [31:0] nrd1;
        logic [31:0] nrd2;
        logic        nb1;
    } exp_t;

    exp_t exp_q[$];

    rf_bypass_sb #(.XLEN(32), .NREG(32), .BYPASS(1), .RST_CLEAR(1)) u_dut (
        .clk(clk), .reset(reset), .we3(we3), .a3(a3), .wd3(wd3), .a1(a1), .a2(a2),
        .rd1(rd1), .rd2(rd2), .sb_set(sb_set), .sb_addr(sb_addr),
        .busy1(busy1), .busy2(busy2), .stall(stall)
    );

    rf_bypass_sb #(.XLEN(32), .NREG(32), .BYPASS(0), .RST_CLEAR(0)) u_nb (
        .clk(clk), .reset(reset), .we3(we3), .a3(a3), .wd3(wd3), .a1(a1), .a2(a2),
        .rd1(n_rd1), .rd2(n_rd2), .sb_set(sb_set), .sb_addr(sb_addr),
        .busy1(n_busy1), .busy2(n_busy2), .stall(n_stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void cmp(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", n, act, req);
        end
    endfunction

    // Monitor: pops every expectation tagged for the current cycle at the negedge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s stale: got cycle %0d expected cycle %0d", e.name, cyc, e.cyc);
            end else begin
                $display("txn %-14s rd1=%08h rd2=%08h busy=%b%b stall=%b | nb rd1=%08h rd2=%08h busy1=%b",
                         e.name, rd1, rd2, busy1, busy2, stall, n_rd1, n_rd2, n_busy1);
                cmp({e.name, ".rd1"},   rd1,   e.rd1);
                cmp({e.name, ".rd2"},   rd2,   e.rd2);
                cmp({e.name, ".busy1"}, 32'(busy1), 32'(e.b1));
                cmp({e.name, ".busy2"}, 32'(busy2), 32'(e.b2));
                cmp({e.name, ".stall"}, 32'(stall), 32'(e.b1 | e.b2));
                if (e.unb) begin
                    cmp({e.name, ".nb_rd1"},   n_rd1,   e.nrd1);
                    cmp({e.name, ".nb_rd2"},   n_rd2,   e.nrd2);
                    cmp({e.name, ".nb_busy1"}, 32'(n_busy1), 32'(e.nb1));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic i_we, input logic [4:0] i_a3, input logic [31:0] i_wd,
                       input logic [4:0] i_a1, input logic [4:0] i_a2,
                       input logic i_set, input logic [4:0] i_sa);
        we3 = i_we; a3 = i_a3; wd3 = i_wd; a1 = i_a1; a2 = i_a2;
        sb_set = i_set; sb_addr = i_sa;
    endtask

    task automatic expect_rf(input string n, input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                             input logic e_b1, input logic e_b2, input bit unb,
                             input logic [31:0] e_nrd1, input logic [31:0] e_nrd2,
                             input logic e_nb1);
        exp_t e;
        e.cyc = cyc; e.name = n; e.rd1 = e_rd1; e.rd2 = e_rd2; e.b1 = e_b1; e.b2 = e_b2;
        e.unb = unb; e.nrd1 = e_nrd1; e.nrd2 = e_nrd2; e.nb1 = e_nb1;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0);
        step();
        // Write and set during reset must both be discarded; bypass suppressed.
        drv(1, 5, 32'hAAAA_AAAA, 5, 5, 1, 5);
        expect_rf("rst_override", 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        drv(0, 0, 0, 5, 0, 0, 0);
        expect_rf("rst_release", 0, 0, 0, 0, 0, 0, 0, 0);

        // 1: reset then read
        step(); drv(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
        expect_rf("t1_write", 0, 0, 0, 0, 1, 0, 0, 0);
        step(); drv(0, 0, 0, 5, 0, 0, 0);
        expect_rf("t1_read", 32'hDEAD_BEEF, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);

        // preload x3, x4, x7, x9 for later tests
        step(); drv(1, 3, 32'h30, 0, 0, 0, 0);
        step(); drv(1, 4, 32'h40, 0, 0, 0, 0);
        step(); drv(1, 7, 32'h11, 0, 0, 0, 0);
        step(); drv(1, 9, 32'h55, 0, 0, 0, 0);

        // 2: x0 immutable and never pending
        step(); drv(1, 0, 32'hFFFF_FFFF, 0, 0, 1, 0);
        expect_rf("t2_wr_x0", 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(); drv(0, 0, 0, 0, 0, 0, 0);
            expect_rf("t2_read_x0", 0, 0, 0, 0, 1, 0, 0, 0);
        end

        // 3: bypass on both ports
        step(); drv(1, 7, 32'h22, 7, 7, 0, 0);
        expect_rf("t3_same_cyc", 32'h22, 32'h22, 0, 0, 1, 32'h11, 32'h11, 0);
        step(); drv(0, 0, 0, 7, 7, 0, 0);
        expect_rf("t3_next_cyc", 32'h22, 32'h22, 0, 0, 1, 32'h22, 32'h22, 0);

        // 4: scoreboard lifecycle on x9
        step(); drv(0, 0, 0, 9, 0, 1, 9);
        expect_rf("t4_set", 32'h55, 0, 0, 0, 1, 32'h55, 0, 0);
        step(); drv(0, 0, 0, 9, 0, 0, 0);
        expect_rf("t4_busy", 32'h55, 0, 1, 0, 1, 32'h55, 0, 1);
        step(); drv(1, 9, 32'h1234, 9, 0, 0, 0);
        expect_rf("t4_wb", 32'h1234, 0, 0, 0, 1, 32'h55, 0, 1);
        step(); drv(0, 0, 0, 9, 0, 0, 0);
        expect_rf("t4_after_wb", 32'h1234, 0, 0, 0, 1, 32'h1234, 0, 0);

        // 5: simultaneous set/clear on x3, then set x4 with clear x3
        step(); drv(0, 0, 0, 3, 4, 1, 3);
        expect_rf("t5_set3", 32'h30, 32'h40, 0, 0, 1, 32'h30, 32'h40, 0);
        step(); drv(1, 3, 32'h33, 3, 4, 1, 3);
        expect_rf("t5_set_clr3", 32'h33, 32'h40, 0, 0, 1, 32'h30, 32'h40, 1);
        step(); drv(0, 0, 0, 3, 4, 0, 0);
        expect_rf("t5_still3", 32'h33, 32'h40, 1, 0, 1, 32'h33, 32'h40, 1);
        step(); drv(1, 3, 32'h34, 3, 4, 1, 4);
        expect_rf("t5_set4_clr3", 32'h34, 32'h40, 0, 0, 1, 32'h33, 32'h40, 1);
        step(); drv(0, 0, 0, 3, 4, 0, 0);
        expect_rf("t5_x4_busy", 32'h34, 32'h40, 0, 1, 1, 32'h34, 32'h40, 0);
        step(); drv(1, 4, 32'h44, 3, 4, 0, 0);
        expect_rf("t5_clr4", 32'h34, 32'h44, 0, 0, 1, 32'h34, 32'h40, 0);

        // 6: async reset mid-stream with x9 pending
        step(); drv(1, 9, 32'h55, 9, 0, 1, 9);
        expect_rf("t6_wr_set9", 32'h55, 0, 0, 0, 1, 32'h1234, 0, 0);
        step(); drv(0, 0, 0, 9, 0, 0, 0);
        expect_rf("t6_busy9", 32'h55, 0, 1, 0, 1, 32'h55, 0, 1);
        step(); drv(0, 0, 0, 9, 3, 0, 0);
        reset = 1'b1;
        expect_rf("t6_async_rst", 0, 0, 0, 0, 1, 32'h55, 32'h34, 0);
        #6;
        reset = 1'b0;
        step(); drv(0, 0, 0, 9, 3, 0, 0);
        expect_rf("t6_post_rst", 0, 0, 0, 0, 1, 32'h55, 32'h34, 0);
        step(); drv(1, 9, 32'h66, 9, 0, 0, 0);
        expect_rf("t6_wr_after", 32'h66, 0, 0, 0, 1, 32'h55, 0, 0);
        step(); drv(0, 0, 0, 9, 0, 0, 0);
        expect_rf("t6_rd_after", 32'h66, 0, 0, 0, 1, 32'h66, 0, 0);

        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_bypass_sb.md
Name: rf_bypass_sb

Overview:
Parametrised integer register file for the RV32 core. It is the next generation of the 32x32 register file and adds:
- configurable width and depth
- asynchronous reset that clears the array
- optional write-to-read bypass
- a pending-write scoreboard, so decode can stall on operands owned by long-latency producers (loads, multi-cycle ALU).

It sits between decode (two read ports plus scoreboard set) and writeback (one write port, which also clears the scoreboard).

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers; must be a power of two, at least 2
AW, $clog2(NREG), address width; derived, do not override
BYPASS, 1, 1: same-cycle write data forwarded to read ports; 0: read returns the old array value
RST_CLEAR, 1, 1: reset zeroes all registers; 0: reset clears only the scoreboard

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high
we3  in  1  write enable for the writeback port
a3  in  AW  write address
wd3  in  XLEN  write data
a1  in  AW  read address, port 1
a2  in  AW  read address, port 2
rd1  out  XLEN  read data, port 1 (combinational)
rd2  out  XLEN  read data, port 2 (combinational)
sb_set  in  1  mark register sb_addr as pending
sb_addr  in  AW  register claimed by the issuing long-latency instruction
busy1  out  1  operand at a1 is pending (combinational)
busy2  out  1  operand at a2 is pending (combinational)
stall  out  1  busy1 | busy2

Behaviour:
- Storage: rf[NREG] of XLEN bits, plus pend[NREG] of 1 bit. Register 0 is hardwired to zero.
  - Writes to a3==0 are discarded.
  - rd1/rd2 return 0 for address 0, regardless of bypass.
  - pend[0] is never set.
- Reset, asynchronous, while high:
  - all pend bits cleared;
  - if RST_CLEAR=1, all rf entries set to 0;
  - during reset, rd*=0 when RST_CLEAR=1, and busy*=0 and stall=0 in all configurations.
  - Reset mid-operation overrides any concurrent we3 or sb_set.
- Write: at posedge with we3=1 and a3!=0, rf[a3]<=wd3.
- Read, combinational:
  - If BYPASS=1, we3=1, a3!=0 and a3==aN, then rdN=wd3.
  - Otherwise rdN=rf[aN], or 0 when aN==0.
  - Both ports may read the same address.
- Scoreboard update at posedge:
  - clear: we3 && a3!=0 gives pend[a3]<=0;
  - set: sb_set && sb_addr!=0 gives pend[sb_addr]<=1;
  - set and clear to the same register in the same cycle: set wins, pend stays 1 (new producer issued behind the retiring one);
  - set and clear to different registers: both apply.
- Busy, combinational:
  - busyN = pend[aN] & (aN!=0), then masked to 0 when BYPASS=1 && we3 && a3==aN, because the data arriving this cycle satisfies the operand.
  - With BYPASS=0 there is no masking: busy drops the cycle after the write.
- Latency:
  - write visible on reads: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0;
  - sb_set visible on busy: the next cycle.
- sb_set on an already-pending register: stays pending. No counting; one outstanding producer per register is the pipeline's contract.
- No X propagation: every output is fully defined from reset deassertion onward.

Test Plan:
1. Reset then read: assert reset, write 0xDEADBEEF to x5 after release, read a1=5 with a2=0 the next cycle -> rd1=0xDEADBEEF, rd2=0. Before the write, rd1=0 (RST_CLEAR=1).
2. x0 immutable: we3=1, a3=0, wd3=0xFFFFFFFF; sb_set=1, sb_addr=0 -> rd1(a1=0)=0, busy1=0 on every later cycle.
3. Bypass:
   - BYPASS=1: rf[7]=0x11; same cycle we3=1, a3=7, wd3=0x22, a1=a2=7 -> rd1=rd2=0x22.
   - BYPASS=0: same stimulus gives rd1=0x11 that cycle and 0x22 the next.
4. Scoreboard lifecycle: sb_set x9; next cycle a1=9 -> busy1=1, stall=1; writeback we3 on x9 with wd3=0x1234:
   - BYPASS=1: busy1=0 that cycle, rd1=0x1234;
   - BYPASS=0: busy1=0 and rd1=0x1234 the following cycle.
5. Simultaneous set and clear on x3 -> pend[3] stays 1, busy on a1=3 next cycle is 1. Set x4 with clear x3 -> x3 free, x4 busy.
6. Async reset mid-stream: with pend[9]=1 and rf[9]=0x55, pulse reset between clock edges -> busy1 (a1=9) drops immediately without a clock edge; rd1=0 (RST_CLEAR=1) or 0x55 (RST_CLEAR=0).
